// File: rtl/fp_addsub_seq.sv
// Sequential IEEE-754 single-precision adder/subtractor.
// Denormals flush to zero and alignment/normalisation truncate, so no rounding is done.
// One operation runs at a time. A start while busy is ignored.
module fp_addsub_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [2:0] {
        StIdle,
        StUnpack,
        StAlign,
        StAdd,
        StNorm,
        StDone
    } state_e;

    state_e      r_state;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_op;
    logic        r_sign_l;
    logic        r_sign_s;
    logic [7:0]  r_exp;
    logic [24:0] r_mant_l;
    logic [24:0] r_mant_s;
    logic [7:0]  r_diff;
    logic [24:0] r_sum;
    logic [31:0] r_result;

    state_e      w_state_nxt;
    logic [31:0] w_a_nxt;
    logic [31:0] w_b_nxt;
    logic        w_op_nxt;
    logic        w_sign_l_nxt;
    logic        w_sign_s_nxt;
    logic [7:0]  w_exp_nxt;
    logic [24:0] w_mant_l_nxt;
    logic [24:0] w_mant_s_nxt;
    logic [7:0]  w_diff_nxt;
    logic [24:0] w_sum_nxt;
    logic [31:0] w_result_nxt;

    // Unpacked views of the latched operands
    logic [7:0]  w_exp_a;
    logic [7:0]  w_exp_b;
    logic [24:0] w_mant_a;
    logic [24:0] w_mant_b;
    logic        w_sign_b_eff;
    logic        w_a_is_l;
    logic [7:0]  w_exp_l;
    logic [7:0]  w_exp_s;
    logic [24:0] w_mant_l;
    logic [24:0] w_mant_s;
    logic [7:0]  w_diff;
    logic [7:0]  w_exp_inc;

    assign w_exp_a      = r_a[30:23];
    assign w_exp_b      = r_b[30:23];
    assign w_mant_a     = (w_exp_a != 8'd0) ? {2'b01, r_a[22:0]} : 25'd0;
    assign w_mant_b     = (w_exp_b != 8'd0) ? {2'b01, r_b[22:0]} : 25'd0;
    assign w_sign_b_eff = r_b[31] ^ r_op;
    // Ties keep A as the larger operand
    assign w_a_is_l     = {w_exp_a, w_mant_a} >= {w_exp_b, w_mant_b};
    assign w_exp_l      = w_a_is_l ? w_exp_a : w_exp_b;
    assign w_exp_s      = w_a_is_l ? w_exp_b : w_exp_a;
    assign w_mant_l     = w_a_is_l ? w_mant_a : w_mant_b;
    assign w_mant_s     = w_a_is_l ? w_mant_b : w_mant_a;
    assign w_diff       = w_exp_l - w_exp_s;
    assign w_exp_inc    = r_exp + 8'd1;

    assign result = r_result;

    // Next-state, datapath next values and status outputs
    always_comb begin
        w_state_nxt  = r_state;
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_op_nxt     = r_op;
        w_sign_l_nxt = r_sign_l;
        w_sign_s_nxt = r_sign_s;
        w_exp_nxt    = r_exp;
        w_mant_l_nxt = r_mant_l;
        w_mant_s_nxt = r_mant_s;
        w_diff_nxt   = r_diff;
        w_sum_nxt    = r_sum;
        w_result_nxt = r_result;
        busy         = (r_state != StIdle);
        done         = (r_state == StDone);

        case (r_state)
            StIdle: begin
                if (start) begin
                    w_a_nxt     = a;
                    w_b_nxt     = b;
                    w_op_nxt    = op;
                    w_state_nxt = StUnpack;
                end
            end
            StUnpack: begin
                if (w_exp_a == 8'hFF) begin
                    w_result_nxt = r_a;
                    w_state_nxt  = StDone;
                end else if (w_exp_b == 8'hFF) begin
                    w_result_nxt = {w_sign_b_eff, r_b[30:0]};
                    w_state_nxt  = StDone;
                end else begin
                    w_sign_l_nxt = w_a_is_l ? r_a[31] : w_sign_b_eff;
                    w_sign_s_nxt = w_a_is_l ? w_sign_b_eff : r_a[31];
                    w_exp_nxt    = w_exp_l;
                    w_mant_l_nxt = w_mant_l;
                    w_mant_s_nxt = w_mant_s;
                    w_diff_nxt   = w_diff;
                    if (w_diff == 8'd0) begin
                        w_state_nxt = StAdd;
                    end else if (w_diff >= 8'd25) begin
                        // Smaller operand is entirely shifted out
                        w_mant_s_nxt = 25'd0;
                        w_state_nxt  = StAdd;
                    end else begin
                        w_state_nxt = StAlign;
                    end
                end
            end
            StAlign: begin
                w_mant_s_nxt = r_mant_s >> 1;
                w_diff_nxt   = r_diff - 8'd1;
                if (r_diff == 8'd1) begin
                    w_state_nxt = StAdd;
                end
            end
            StAdd: begin
                // The swap guarantees mant_l >= mant_s, so the difference is never negative
                w_sum_nxt   = (r_sign_l == r_sign_s) ? (r_mant_l + r_mant_s)
                                                     : (r_mant_l - r_mant_s);
                w_state_nxt = StNorm;
            end
            StNorm: begin
                if (r_sum == 25'd0) begin
                    w_result_nxt = 32'h0000_0000;
                    w_state_nxt  = StDone;
                end else if (r_sum[24]) begin
                    w_sum_nxt    = r_sum >> 1;
                    w_exp_nxt    = w_exp_inc;
                    w_result_nxt = (w_exp_inc == 8'hFF) ? {r_sign_l, 8'hFF, 23'h0}
                                                        : {r_sign_l, w_exp_inc, r_sum[23:1]};
                    w_state_nxt  = StDone;
                end else if (r_sum[23]) begin
                    w_result_nxt = {r_sign_l, r_exp, r_sum[22:0]};
                    w_state_nxt  = StDone;
                end else if (r_exp == 8'd1) begin
                    // A further left shift would reach exponent 0: flush to zero
                    w_result_nxt = 32'h0000_0000;
                    w_state_nxt  = StDone;
                end else begin
                    w_sum_nxt = r_sum << 1;
                    w_exp_nxt = r_exp - 8'd1;
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_op     <= 1'b0;
            r_sign_l <= 1'b0;
            r_sign_s <= 1'b0;
            r_exp    <= 8'd0;
            r_mant_l <= 25'd0;
            r_mant_s <= 25'd0;
            r_diff   <= 8'd0;
            r_sum    <= 25'd0;
            r_result <= 32'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_a      <= w_a_nxt;
            r_b      <= w_b_nxt;
            r_op     <= w_op_nxt;
            r_sign_l <= w_sign_l_nxt;
            r_sign_s <= w_sign_s_nxt;
            r_exp    <= w_exp_nxt;
            r_mant_l <= w_mant_l_nxt;
            r_mant_s <= w_mant_s_nxt;
            r_diff   <= w_diff_nxt;
            r_sum    <= w_sum_nxt;
            r_result <= w_result_nxt;
        end
    end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Self-checking bench for fp_addsub_seq: directed corner cases plus random operands
// compared against a truncating arithmetic reference model.
module tb_fp_addsub_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int total;
    int bad;

    fp_addsub_seq dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    // Reference: result and latency, where latency counts clock edges from the
    // start-sampling edge to the edge that raises done (both inclusive).
    function automatic void ref_model(input logic [31:0] fa, input logic [31:0] fb,
                                      input logic fop, output logic [31:0] res,
                                      output int lat);
        int     ea, eb, el, es, e, diff, align, nrm;
        longint ma, mb, ml, ms, sum;
        logic   sa, sb, sl, ss, uf;
        ea = int'(fa[30:23]);
        eb = int'(fb[30:23]);
        sa = fa[31];
        sb = fb[31] ^ fop;
        if (ea == 255) begin
            res = fa;
            lat = 2;
            return;
        end
        if (eb == 255) begin
            res = {sb, fb[30:0]};
            lat = 2;
            return;
        end
        ma = (ea != 0) ? (longint'(fa[22:0]) + 64'h80_0000) : 0;
        mb = (eb != 0) ? (longint'(fb[22:0]) + 64'h80_0000) : 0;
        if (ea > eb || (ea == eb && ma >= mb)) begin
            el = ea; es = eb; ml = ma; ms = mb; sl = sa; ss = sb;
        end else begin
            el = eb; es = ea; ml = mb; ms = ma; sl = sb; ss = sa;
        end
        diff  = el - es;
        align = (diff > 0 && diff < 25) ? diff : 0;
        ms    = (diff >= 25) ? 0 : (ms >> diff);
        sum   = (sl == ss) ? (ml + ms) : (ml - ms);
        e     = el;
        nrm   = 1;
        if (sum == 0) begin
            res = 32'h0;
        end else if (sum >= 64'h100_0000) begin
            e = e + 1;
            if (e >= 255) res = {sl, 8'hFF, 23'h0};
            else          res = {sl, 8'(e), 23'(sum >> 1)};
        end else begin
            uf = 1'b0;
            while (sum < 64'h80_0000 && !uf) begin
                if (e == 1) begin
                    uf = 1'b1;
                end else begin
                    sum = sum << 1;
                    e   = e - 1;
                    nrm = nrm + 1;
                end
            end
            res = uf ? 32'h0 : {sl, 8'(e), 23'(sum)};
        end
        lat = 4 + align + nrm - 1;
    endfunction

    // Runs one operation; lat=-1 on timeout; tail_ok says the DUT is idle the cycle after done
    task automatic do_op(input logic [31:0] ia, input logic [31:0] ib, input logic iop,
                         output logic [31:0] res, output int lat, output logic busy_ok,
                         output logic tail_ok);
        @(negedge clk);
        a = ia; b = ib; op = iop; start = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        lat     = 1;
        busy_ok = busy;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            busy_ok &= busy;
        end
        res = result;
        if (!done) lat = -1;
        @(posedge clk);
        #1;
        tail_ok = !done && !busy && (result === res);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; a = 32'h3F80_0000; b = 32'h3F80_0000; op = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            bad++;
            $display("FAIL reset_state: busy=%b done=%b result=%h, need 0 0 00000000",
                     busy, done, result);
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL start_during_reset: busy=%b, need 0", busy);
        end
    endtask

    task automatic test_basic_add();
        logic [31:0] res;
        int          lat;
        logic        bok, tok;
        do_op(32'h3F80_0000, 32'h3F80_0000, 1'b0, res, lat, bok, tok);
        total++;
        if (res !== 32'h4000_0000) begin
            bad++; $display("FAIL one_plus_one: result=%h need 40000000", res);
        end
        total++;
        if (lat != 4) begin
            bad++; $display("FAIL one_plus_one_latency: got %0d need 4", lat);
        end
        total++;
        if (bok !== 1'b1) begin
            bad++; $display("FAIL one_plus_one_busy: busy dropped during op");
        end
        total++;
        if (tok !== 1'b1) begin
            bad++; $display("FAIL one_plus_one_tail: done/busy not idle after pulse");
        end
    endtask

    task automatic test_align();
        logic [31:0] res;
        int          lat;
        logic        bok, tok;
        do_op(32'h4040_0000, 32'h3F80_0000, 1'b1, res, lat, bok, tok);
        total++;
        if (res !== 32'h4000_0000) begin
            bad++; $display("FAIL three_minus_one: result=%h need 40000000", res);
        end
        total++;
        if (lat != 5) begin
            bad++; $display("FAIL three_minus_one_latency: got %0d need 5", lat);
        end
    endtask

    task automatic test_zero_overflow();
        logic [31:0] res;
        int          lat;
        logic        bok, tok;
        do_op(32'h3F80_0000, 32'h3F80_0000, 1'b1, res, lat, bok, tok);
        total++;
        if (res !== 32'h0000_0000) begin
            bad++; $display("FAIL cancel_to_zero: result=%h need 00000000", res);
        end
        do_op(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, res, lat, bok, tok);
        total++;
        if (res !== 32'h7F80_0000) begin
            bad++; $display("FAIL overflow_inf: result=%h need 7f800000", res);
        end
        total++;
        if (lat != 4) begin
            bad++; $display("FAIL overflow_latency: got %0d need 4", lat);
        end
    endtask

    task automatic test_special();
        logic [31:0] res;
        int          lat, ndone, first;
        logic        bok, tok;
        // Infinity operand A, with a second start pulsed while busy
        @(negedge clk);
        a = 32'h7F80_0000; b = 32'h3F80_0000; op = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        a = 32'h3F80_0000; b = 32'h3F80_0000;
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL special_busy: busy=%b need 1", busy);
        end
        ndone = 0;
        first = -1;
        for (int i = 2; i <= 8; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                ndone++;
                if (first < 0) begin
                    first = i;
                    res   = result;
                end
            end
        end
        total++;
        if (ndone != 1) begin
            bad++; $display("FAIL busy_start_ignored: %0d done pulses, need 1", ndone);
        end
        total++;
        if (first != 2) begin
            bad++; $display("FAIL special_latency: got %0d need 2", first);
        end
        total++;
        if (res !== 32'h7F80_0000) begin
            bad++; $display("FAIL special_a_inf: result=%h need 7f800000", res);
        end
        // Infinity operand B under subtraction flips its sign
        do_op(32'h3F80_0000, 32'h7F80_0000, 1'b1, res, lat, bok, tok);
        total++;
        if (res !== 32'hFF80_0000 || lat != 2) begin
            bad++; $display("FAIL special_b_inf: result=%h lat=%0d need ff800000 2", res, lat);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        int          lat;
        logic        bok, tok;
        // Exponent difference 23 keeps the DUT in ALIGN for many cycles
        @(negedge clk);
        a = 32'h4B00_0000; b = 32'h3F80_0000; op = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            bad++;
            $display("FAIL reset_mid_op: busy=%b done=%b result=%h, need 0 0 00000000",
                     busy, done, result);
        end
        @(negedge clk);
        rst = 1'b0;
        do_op(32'h3F80_0000, 32'h3F80_0000, 1'b0, res, lat, bok, tok);
        total++;
        if (res !== 32'h4000_0000 || lat != 4) begin
            bad++;
            $display("FAIL after_reset_op: result=%h lat=%0d need 40000000 4", res, lat);
        end
    endtask

    task automatic test_random();
        logic [31:0] ra, rb, res, exp_res;
        logic        rop, bok, tok;
        int          lat, exp_lat, ea, eb;
        for (int n = 0; n < 300; n++) begin
            ea  = int'($urandom_range(1, 254));
            eb  = int'($urandom_range(1, 254));
            if ($urandom_range(0, 3) != 0) begin
                eb = ea + int'($urandom_range(0, 60)) - 30;
                if (eb < 1) eb = 1;
                if (eb > 254) eb = 254;
            end
            ra  = {1'($urandom), 8'(ea), 23'($urandom)};
            rb  = {1'($urandom), 8'(eb), 23'($urandom)};
            rop = 1'($urandom);
            if ($urandom_range(0, 7) == 0) rb = {rb[31], ra[30:0]};
            if ($urandom_range(0, 7) == 0) rb = {rb[31], ra[30:23], ra[22:0] ^ 23'(1 << $urandom_range(0, 3))};
            ref_model(ra, rb, rop, exp_res, exp_lat);
            do_op(ra, rb, rop, res, lat, bok, tok);
            total++;
            if (res !== exp_res) begin
                bad++;
                $display("FAIL random_result: a=%h b=%h op=%b got %h need %h",
                         ra, rb, rop, res, exp_res);
            end
            total++;
            if (lat != exp_lat) begin
                bad++;
                $display("FAIL random_latency: a=%h b=%h op=%b got %0d need %0d",
                         ra, rb, rop, lat, exp_lat);
            end
            total++;
            if (tok !== 1'b1) begin
                bad++;
                $display("FAIL random_single_done: a=%h b=%h op=%b extra done or busy", ra, rb, rop);
            end
        end
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; start = 1'b0; op = 1'b0; a = 32'h0; b = 32'h0;
        total = 0;
        bad   = 0;
        test_reset();
        test_basic_add();
        test_align();
        test_zero_overflow();
        test_special();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
